// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared widths, register-0 constant and flattened-port slice helper
//           for the multi-port register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Widest flattened bus the slice helper accepts
    localparam int SLICE_MAX = 256;

    function automatic logic [SLICE_MAX-1:0] port_slice(
        input logic [SLICE_MAX-1:0] vec,
        input int                   idx,
        input int                   w
    );
        logic [SLICE_MAX-1:0] mask;
        mask = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
        return (vec >> (idx * w)) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : Per-register busy bits (issue sets, writeback clears, set wins)
//           with per-read-port busy lookup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_bypass,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W-1:0] w_wa;
    logic [ADDR_W-1:0] w_ra;

    // Clears applied first so a same-cycle issue to that register wins
    always_comb begin
        w_busy_nxt = r_busy;
        w_wa       = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wa = ADDR_W'(port_slice(SLICE_MAX'(wr_addr), j, ADDR_W));
            if (we[j]) begin
                w_busy_nxt[w_wa] = 1'b0;
            end
        end
        if (iss_valid && !(ZERO_REG != 0 && iss_addr == c_zero)) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        rd_busy = '0;
        w_ra    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra       = ADDR_W'(port_slice(SLICE_MAX'(rd_addr), k, ADDR_W));
            rd_busy[k] = r_busy[w_ra] && !rd_bypass[k]
                         && !(ZERO_REG != 0 && w_ra == c_zero);
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Brief   : Parametrised multi-port register file with register-0 hardwiring,
//           busy scoreboard and optional same-cycle write-to-read bypass
//           (enabled by defining REGFILE_BYPASS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [NUM_WR-1:0]        w_wr_ok;
    logic [NUM_RD-1:0]        w_rd_byp;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [ADDR_W-1:0]        w_ra;
    logic [DATA_W-1:0]        w_byp_val;

    // A write to a hardwired register 0 neither commits nor bypasses
    always_comb begin
        w_wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = we[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == c_zero);
        end
    end

    // Ascending port order lets the higher index win on an address clash
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_byp  = '0;
        w_ra      = '0;
        w_byp_val = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra      = rd_addr[k*ADDR_W +: ADDR_W];
            w_byp_val = '0;
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j] && wr_addr[j*ADDR_W +: ADDR_W] == w_ra) begin
                    w_rd_byp[k] = 1'b1;
                    w_byp_val   = wr_data[j*DATA_W +: DATA_W];
                end
            end
`endif
            if (ZERO_REG != 0 && w_ra == c_zero) begin
                w_rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (w_rd_byp[k]) begin
                w_rd_data[k*DATA_W +: DATA_W] = w_byp_val;
            end else begin
                w_rd_data[k*DATA_W +: DATA_W] = r_mem[w_ra];
            end
        end
    end

    assign rd_data = w_rd_data;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rd_addr   (rd_addr),
        .rd_bypass (w_rd_byp),
        .rd_busy   (rd_busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Directed table-driven bench for regfile_mp (default parameters);
//           expectations follow REGFILE_BYPASS_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;

    int errors = 0;
    int checks = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] we_i, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic iv, input logic [4:0] ia,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] ed0, input logic [31:0] ed1,
                       input logic eb0, input logic eb1);
        vec_t v;
        v.we = we_i; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iv = iv; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 2'b00; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle_inputs();

        add(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd7,
            BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0,
            32'hDEADBEEF, 32'h0, 0, 0);
        add(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 0, 5'd0, 5'd7, 5'd3,
            BYP ? 32'h22222222 : 32'h0, 32'hDEADBEEF, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd7,
            32'h22222222, 32'h22222222, 0, 0);
        add(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0,
            32'h0, 32'h0, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0,
            32'h0, 32'h0, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd3,
            32'h0, 32'hDEADBEEF, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9,
            32'h0, 32'h0, 1, 1);
        add(2'b01, 5'd9, 32'h5, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd7,
            BYP ? 32'h5 : 32'h0, 32'h22222222, !BYP, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9,
            32'h5, 32'h5, 0, 0);
        add(2'b10, 5'd0, 32'h0, 5'd4, 32'hA, 1, 5'd4, 5'd4, 5'd9,
            BYP ? 32'hA : 32'h0, 32'h5, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd4,
            32'hA, 32'hA, 1, 1);
        add(2'b11, 5'd12, 32'hCAFE, 5'd12, 32'h12345678, 0, 5'd0, 5'd12, 5'd4,
            BYP ? 32'h12345678 : 32'h0, 32'hA, 0, 1);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd12,
            32'h12345678, 32'h12345678, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd9,
            32'h5, 32'h5, 0, 0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd4,
            32'h5, 32'hA, 1, 1);
        add(2'b01, 5'd9, 32'h6, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9,
            BYP ? 32'h6 : 32'h5, BYP ? 32'h6 : 32'h5, !BYP, !BYP);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd4,
            32'h6, 32'hA, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #2;
            chk($sformatf("reset data0 a=%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("reset data1 a=%0d", 31 - a), rd_data[63:32], 32'h0);
            chk($sformatf("reset busy a=%0d", a), {30'h0, rd_busy}, 32'h0);
            @(negedge clk);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            we        = vecs[i].we;
            wr_addr   = {vecs[i].wa1, vecs[i].wa0};
            wr_data   = {vecs[i].wd1, vecs[i].wd0};
            iss_valid = vecs[i].iv;
            iss_addr  = vecs[i].ia;
            rd_addr   = {vecs[i].ra1, vecs[i].ra0};
            #2;
            chk($sformatf("vec%0d data0", i), rd_data[31:0], vecs[i].ed0);
            chk($sformatf("vec%0d data1", i), rd_data[63:32], vecs[i].ed1);
            chk($sformatf("vec%0d busy0", i), {31'h0, rd_busy[0]}, {31'h0, vecs[i].eb0});
            chk($sformatf("vec%0d busy1", i), {31'h0, rd_busy[1]}, {31'h0, vecs[i].eb1});
        end

        // Reset wins over a simultaneous write and issue
        @(negedge clk);
        rst       = 1'b1;
        we        = 2'b10;
        wr_addr   = {5'd4, 5'd0};
        wr_data   = {32'hBB, 32'h0};
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        rd_addr   = {5'd5, 5'd4};
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #2;
        chk("rst data4", rd_data[31:0], 32'h0);
        chk("rst data5", rd_data[63:32], 32'h0);
        chk("rst busy", {30'h0, rd_busy}, 32'h0);
        rd_addr = {5'd12, 5'd9};
        #1;
        chk("rst data9", rd_data[31:0], 32'h0);
        chk("rst data12", rd_data[63:32], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
